// File: rtl/picorv32_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_mem_pkg
// Purpose  : Shared types and helpers for PicoRV32 memory-side blocks:
//            responder FSM state encoding, word-address extraction and
//            byte-lane merge.
// Revision : 1.0 - initial release
// ============================================================================
package picorv32_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } mem_state_e;

  // Word index of a byte address; the low two bits select a byte lane only.
  function automatic logic [29:0] word_addr(input logic [31:0] addr);
    return addr[31:2];
  endfunction

  // Replace the bytes of old_word whose strobe bit is set with those of new_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  wstrb);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/picorv32_mem_proto_mon.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_mem_proto_mon
// Purpose  : Compares the live core request against the request latched at
//            transfer start and raises a sticky protocol-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module picorv32_mem_proto_mon
  import picorv32_mem_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        active,      // responder is in WAIT or ACK
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        lat_instr,
  input  logic [31:0] lat_addr,
  input  logic [31:0] lat_wdata,
  input  logic [3:0]  lat_wstrb,
  output logic        proto_err
);

  logic request_changed;
  logic instr_write;
  logic violation;

  // Live-versus-latched comparison and the always-illegal instruction write.
  always_comb begin
    request_changed = (mem_instr != lat_instr) || (mem_addr  != lat_addr) ||
                      (mem_wdata != lat_wdata) || (mem_wstrb != lat_wstrb);
    instr_write     = mem_valid && mem_instr && (mem_wstrb != 4'h0);
    violation       = instr_write || (active && (!mem_valid || request_changed));
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      proto_err <= 1'b0;
    end else if (violation) begin
      proto_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/picorv32_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_mem_responder
// Purpose  : Slave responder for the PicoRV32 native memory bus. Inserts a
//            bounded number of wait states, keeps a byte-accurate shadow of
//            one tracked word and flags core-side protocol violations.
// Revision : 1.0 - initial release
// ============================================================================
module picorv32_mem_responder
  import picorv32_mem_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WCNT_W   = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  input  logic              stall_req,
  input  logic [31:0]       rand_rdata,
  input  logic [31:0]       track_addr,
  output logic [31:0]       track_data,
  output logic              track_valid,
  output logic [WCNT_W-1:0] wait_count,
  output logic              proto_err
);

  localparam logic [WCNT_W-1:0] MAX_WAIT_C = WCNT_W'(MAX_WAIT);

  mem_state_e  state, state_nxt;

  logic        lat_instr;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;

  logic [29:0] track_word_prev;
  logic        track_changed;

  // Request as seen by the ACK-entry logic: live bus when leaving IDLE,
  // latched copy when leaving WAIT.
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic        enter_ack;
  logic        req_hit;
  logic        lat_hit;

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (mem_valid) state_nxt = stall_req ? ST_WAIT : ST_ACK;
      end
      ST_WAIT: begin
        if (!(stall_req && (wait_count < MAX_WAIT_C))) state_nxt = ST_ACK;
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Derived request/shadow comparisons used by several registers below.
  always_comb begin
    req_addr      = (state == ST_IDLE) ? mem_addr  : lat_addr;
    req_wstrb     = (state == ST_IDLE) ? mem_wstrb : lat_wstrb;
    enter_ack     = (state != ST_ACK) && (state_nxt == ST_ACK);
    req_hit       = word_addr(req_addr) == word_addr(track_addr);
    lat_hit       = word_addr(lat_addr) == word_addr(track_addr);
    track_changed = word_addr(track_addr) != track_word_prev;
    mem_ready     = (state == ST_ACK);
  end

  // Capture the request at transfer start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat_instr <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_wstrb <= 4'h0;
    end else if (state == ST_IDLE && mem_valid) begin
      lat_instr <= mem_instr;
      lat_addr  <= mem_addr;
      lat_wdata <= mem_wdata;
      lat_wstrb <= mem_wstrb;
    end
  end

  // Wait-state counter: starts at 1 on entering WAIT, clears after ACK.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_count <= '0;
    end else begin
      case (state)
        ST_IDLE: if (mem_valid && stall_req) wait_count <= WCNT_W'(1);
        ST_WAIT: if (stall_req && (wait_count < MAX_WAIT_C)) wait_count <= wait_count + 1'b1;
        ST_ACK:  wait_count <= '0;
        default: wait_count <= '0;
      endcase
    end
  end

  // Read data, latched on entry to ACK and held until the next ACK entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_rdata <= 32'h0;
    end else if (enter_ack) begin
      if (req_wstrb != 4'h0)          mem_rdata <= 32'h0;
      else if (req_hit && track_valid) mem_rdata <= track_data;
      else                             mem_rdata <= rand_rdata;
    end
  end

  // Remember the tracked word so a retarget can invalidate the shadow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) track_word_prev <= 30'h0;
    else         track_word_prev <= word_addr(track_addr);
  end

  // Shadow word: retarget invalidates first, then read-init, then write merge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      track_data  <= 32'h0;
      track_valid <= 1'b0;
    end else if (track_changed) begin
      track_valid <= 1'b0;
    end else if (enter_ack && req_wstrb == 4'h0 && req_hit && !track_valid) begin
      track_data  <= rand_rdata;
      track_valid <= 1'b1;
    end else if (state == ST_ACK && lat_wstrb != 4'h0 && lat_hit) begin
      track_data <= byte_merge(track_data, lat_wdata, lat_wstrb);
      if (lat_wstrb == 4'hF) track_valid <= 1'b1;
    end
  end

  picorv32_mem_proto_mon u_proto_mon (
    .clk       (clk),
    .resetn    (resetn),
    .active    (state != ST_IDLE),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .lat_instr (lat_instr),
    .lat_addr  (lat_addr),
    .lat_wdata (lat_wdata),
    .lat_wstrb (lat_wstrb),
    .proto_err (proto_err)
  );

endmodule
`default_nettype wire
